// File: rtl/tl_sram_device.sv
// TileLink-UH device terminating the wide device-side bus: a single-port SRAM
// with a one-cycle registered read. It serves Get, PutFullData and PutPartialData
// bursts. Requests it cannot serve get denied responses. B/C/E are tied off.
module tl_sram_device #(
  parameter int                   DataWidth   = 64,
  parameter int                   AddrWidth   = 56,
  parameter int                   SourceWidth = 1,
  parameter int                   SinkWidth   = 1,
  parameter int                   MaxSize     = 6,
  parameter int                   MemDepth    = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  localparam int                  SizeWidth   = $clog2(MaxSize + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     host_a_ready,
  input  logic                     host_a_valid,
  input  logic [2:0]               host_a_opcode,
  input  logic [2:0]               host_a_param,
  input  logic [SizeWidth-1:0]     host_a_size,
  input  logic [SourceWidth-1:0]   host_a_source,
  input  logic [AddrWidth-1:0]     host_a_address,
  input  logic [DataWidth/8-1:0]   host_a_mask,
  input  logic                     host_a_corrupt,
  input  logic [DataWidth-1:0]     host_a_data,
  input  logic                     host_d_ready,
  output logic                     host_d_valid,
  output logic [2:0]               host_d_opcode,
  output logic [1:0]               host_d_param,
  output logic [SizeWidth-1:0]     host_d_size,
  output logic [SourceWidth-1:0]   host_d_source,
  output logic [SinkWidth-1:0]     host_d_sink,
  output logic                     host_d_denied,
  output logic                     host_d_corrupt,
  output logic [DataWidth-1:0]     host_d_data,
  output logic                     host_b_valid,
  output logic                     host_c_ready,
  output logic                     host_e_ready
);

  localparam int ByteLanes    = DataWidth / 8;
  localparam int LgBytes      = $clog2(ByteLanes);
  localparam int IdxWidth     = $clog2(MemDepth);
  localparam int MemAddrWidth = IdxWidth + LgBytes;
  localparam int CntWidth     = (MaxSize > LgBytes) ? (MaxSize - LgBytes) : 1;
  localparam int MaxBeatsM1   = (MaxSize > LgBytes) ? ((1 << (MaxSize - LgBytes)) - 1) : 0;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITH       = 3'd2;
  localparam logic [2:0] OP_LOGIC       = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_INTENT      = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_ACK} state_e;

  state_e                  state_reg, state_next;
  logic [CntWidth-1:0]     cnt_reg, cnt_next;
  logic [IdxWidth-1:0]     idx_reg, idx_next;
  logic [CntWidth-1:0]     beats_m1_reg;
  logic [2:0]              opcode_reg;
  logic [SizeWidth-1:0]    size_reg;
  logic [SourceWidth-1:0]  source_reg;
  logic                    denied_reg;

  logic                    a_fire, d_fire;
  logic                    req_denied, req_is_put;
  logic [IdxWidth-1:0]     req_index;
  logic [CntWidth-1:0]     req_beats_m1;
  logic                    is_put_reg, ack_has_data;

  logic                    mem_we, mem_re;
  logic [IdxWidth-1:0]     mem_addr;
  logic [DataWidth-1:0]    mem_rdata;

  logic                    unused_inputs;
  assign unused_inputs = ^{host_a_param, host_a_address[LgBytes-1:0]};

  assign host_a_ready = rst_ni && (state_reg == ST_IDLE || state_reg == ST_WRITE);
  assign host_d_valid = (state_reg == ST_READ) || (state_reg == ST_ACK);
  assign a_fire       = host_a_valid && host_a_ready;
  assign d_fire       = host_d_valid && host_d_ready;

  assign host_b_valid = 1'b0;
  assign host_c_ready = 1'b1;
  assign host_e_ready = 1'b1;

  assign is_put_reg   = (opcode_reg == OP_PUT_FULL) || (opcode_reg == OP_PUT_PARTIAL);
  assign ack_has_data = (opcode_reg == OP_ARITH) || (opcode_reg == OP_LOGIC);

  // Decode the A request: window check on the upper address bits, size and opcode legality, beat count.
  always_comb begin
    req_index    = host_a_address[MemAddrWidth-1:LgBytes];
    req_is_put   = (host_a_opcode == OP_PUT_FULL) || (host_a_opcode == OP_PUT_PARTIAL);
    req_denied   = (host_a_address[AddrWidth-1:MemAddrWidth] != BaseAddr[AddrWidth-1:MemAddrWidth])
                || (int'(host_a_size) > MaxSize)
                || !(req_is_put || host_a_opcode == OP_GET || host_a_opcode == OP_INTENT);
    req_beats_m1 = '0;
    if (int'(host_a_size) > MaxSize) begin
      req_beats_m1 = CntWidth'(MaxBeatsM1);
    end else if (int'(host_a_size) > LgBytes) begin
      req_beats_m1 = CntWidth'((1 << (int'(host_a_size) - LgBytes)) - 1);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next state, beat counter, word index and SRAM port control.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (a_fire) begin
          mem_addr = req_index;
          idx_next = req_index + 1'b1;
          case (host_a_opcode)
            OP_GET: begin
              mem_re     = !req_denied;
              cnt_next   = req_beats_m1;
              state_next = ST_READ;
            end
            OP_PUT_FULL, OP_PUT_PARTIAL, OP_ARITH, OP_LOGIC: begin
              mem_we = req_is_put && !req_denied && !host_a_corrupt;
              if (req_beats_m1 != '0) begin
                cnt_next   = req_beats_m1 - 1'b1;
                state_next = ST_WRITE;
              end else begin
                cnt_next   = '0;
                state_next = ST_ACK;
              end
            end
            default: begin
              cnt_next   = '0;
              state_next = ST_ACK;
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (a_fire) begin
          mem_we   = is_put_reg && !denied_reg && !host_a_corrupt;
          idx_next = idx_reg + 1'b1;
          if (cnt_reg == '0) begin
            cnt_next   = beats_m1_reg;
            state_next = ST_ACK;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      ST_READ: begin
        // The RAM output register is the holding stage: the next word is only
        // fetched when the current beat leaves, so a stall never loses data.
        if (d_fire) begin
          if (cnt_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            mem_re   = !denied_reg;
            idx_next = idx_reg + 1'b1;
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (d_fire) begin
          if (!ack_has_data || cnt_reg == '0) state_next = ST_IDLE;
          else                                cnt_next   = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields latched on acceptance, plus the burst counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      idx_reg      <= '0;
      beats_m1_reg <= '0;
      opcode_reg   <= '0;
      size_reg     <= '0;
      source_reg   <= '0;
      denied_reg   <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      if (state_reg == ST_IDLE && a_fire) begin
        beats_m1_reg <= req_beats_m1;
        opcode_reg   <= host_a_opcode;
        size_reg     <= host_a_size;
        source_reg   <= host_a_source;
        denied_reg   <= req_denied;
      end
    end
  end

  // One byte-wide RAM per lane so byte enables map onto independent arrays.
  genvar gi;
  generate
    for (gi = 0; gi < ByteLanes; gi++) begin : g_lane
      logic [7:0] lane_mem [MemDepth];
      logic [7:0] lane_rdata_reg;
      // Lane write on enable, registered read otherwise; contents survive reset.
      always_ff @(posedge clk_i) begin
        if (mem_we && host_a_mask[gi]) lane_mem[mem_addr] <= host_a_data[gi*8 +: 8];
        if (mem_re)                    lane_rdata_reg     <= lane_mem[mem_addr];
      end
      assign mem_rdata[gi*8 +: 8] = lane_rdata_reg;
    end
  endgenerate

  // D channel fields: data beats in READ, a single or data-less ack in ACK.
  always_comb begin
    host_d_param   = '0;
    host_d_sink    = '0;
    host_d_size    = size_reg;
    host_d_source  = source_reg;
    host_d_denied  = denied_reg;
    host_d_opcode  = D_ACCESS_ACK;
    host_d_data    = '0;
    if (state_reg == ST_READ) begin
      host_d_opcode = D_ACCESS_ACK_DATA;
      if (!denied_reg) host_d_data = mem_rdata;
    end else if (opcode_reg == OP_INTENT) begin
      host_d_opcode = D_HINT_ACK;
    end else if (ack_has_data) begin
      host_d_opcode = D_ACCESS_ACK_DATA;
    end
    host_d_corrupt = denied_reg && (host_d_opcode == D_ACCESS_ACK_DATA);
  end

endmodule
